multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised, multi-channel successor to the single-input dual-edge detector. Each of `N_CH` asynchronous level inputs is synchronised, tracked by a per-channel edge FSM, and qualified by a run-time mode (off/rising/falling/both). The block produces one-cycle edge ticks, sticky event flags and saturating edge counters. It sits between raw board inputs (buttons, switches, external strobes) and the control logic that consumes their events.

## Interface
- `N_CH`, default 4: number of independent channels.
- `SYNC_STAGES`, default 2: synchroniser flops per channel; 0 bypasses synchronisation.
- `MEALY`, default 0: 0 selects Moore (registered) ticks; 1 selects Mealy (combinational) ticks.
- `CNT_W`, default 8: per-channel edge counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in` in N_CH: raw level inputs, one bit per channel.
- `mode` in 2*N_CH: per-channel mode, `mode[2i+1:2i]`: 00 off, 01 rising, 10 falling, 11 both.
- `clr` in N_CH: per-channel clear for flag and counter, one-cycle pulse.
- `tick` out N_CH: one-cycle qualified edge pulse per channel.
- `flag` out N_CH: sticky "edge seen" per channel.
- `count` out N_CH*CNT_W: per-channel saturating edge count; channel i occupies `[CNT_W*i +: CNT_W]`.

## Operation
- `s[i]` is the synchronised input: `in[i]` after SYNC_STAGES flops, or raw `in[i]` when SYNC_STAGES=0.
- **Moore FSM, per channel.** States ZERO, RISE, ONE, FALL.
  - ZERO: s=1 goes to RISE, else stays ZERO.
  - RISE: s=1 goes to ONE; s=0 goes to FALL.
  - ONE: s=0 goes to FALL, else stays ONE.
  - FALL: s=0 goes to ZERO; s=1 goes to RISE.
  - Raw edge `re` = (state==RISE); `fe` = (state==FALL).
- **Mealy FSM, per channel.** Single registered level `lvl`.
  - `re` = s & ~lvl; `fe` = ~s & lvl; `lvl` <= s each cycle.
- **Tick qualification.** `tick[i]` = (re & mode[2i]) | (fe & mode[2i+1]).
  - Mode is applied combinationally, so a mode change affects the same cycle's tick.
  - The FSM always tracks s regardless of mode. Enabling a channel therefore never produces a spurious tick.
- **Flag.** Set when tick=1; cleared when clr=1 and tick=0. Simultaneous tick and clr leaves flag=1 (set wins).
- **Counter.**
  - Increments on tick and saturates at 2^CNT_W-1, never wrapping.
  - clr forces 0.
  - Simultaneous clr and tick gives 1.
- **Independence.** Channels do not interact; events on several channels in the same cycle are all reported.
- **Reset.** Synchroniser flops 0, state ZERO / lvl=0, flag 0, count 0. tick is 0 during reset.
  - If `in` is high at reset release, a rising tick is reported, because reset defines the prior level as 0.
- **Reset mid-operation.** All state clears asynchronously. Any in-flight edge is lost; no tick is produced while reset is high.

## Timing
- Reference point: `in` changes between clock edges 0 and 1.
  - s changes after edge S (S=SYNC_STAGES ≥ 1), or immediately when S=0.
- **Moore latency.** tick is high for exactly the cycle following edge S+1.
  - A level held for only one s-cycle yields back-to-back rise and fall ticks, each one cycle long.
- **Mealy latency.** tick is high for the cycle following edge S.
  - When S=0, tick follows `in` combinationally within the same cycle.
  - A glitch on `in` is visible on tick in this configuration; it is documented as unsafe for asynchronous inputs.
- flag and count update on the clock edge that ends the tick cycle, i.e. one cycle after tick is first seen.
- No handshake. The consumer must sample tick every cycle; flag and count exist for slower consumers.

## Structure
- Package `edge_pkg` holds:
  - `edge_state_t` enum {ZERO, RISE, ONE, FALL};
  - mode constants `MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`.
- Sub-module `edge_channel` contains synchroniser, FSM (Moore or Mealy via generate on MEALY), tick qualification, flag and counter for one channel.
- Top level is a generate loop of N_CH `edge_channel` instances plus port slicing.

## Test plan
- Moore, S=2, ch0 mode=11: raise in[0] for 4 cycles then lower it → tick[0] high one cycle at edge 3 after rise and one cycle at edge 3 after fall; count=2, flag=1.
- Mealy, S=0, mode=01: pulse in[1] high 3 cycles → tick[1] high in the same cycles as the rising input, no fall tick; count[1]=1.
- Mode gating: ch2 mode=00 while toggling 5 times, then switch to 10 with input held high, then lower input → exactly one tick (on the fall); no spurious tick on mode change.
- Saturation: CNT_W=3, 10 rising edges on ch3 → count[3]=7, held; then clr with simultaneous tick → count=1, flag=1.
- Reset: assert reset mid-pulse (Moore, in RISE state) → tick, flag, count immediately 0. Release with in high → one rising tick after S+1 edges.
- Multi-channel: simultaneous rising edges on all 4 channels, mode=11 → all tick bits high in the same cycle, all counts=1.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and constants for the multi-channel edge detector.
package edge_pkg;

  // Per-channel Moore edge-tracking states.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RISE = 2'd1,
    ONE  = 2'd2,
    FALL = 2'd3
  } edge_state_t;

  // Per-channel mode encodings: bit 0 enables rising ticks, bit 1 falling.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/multi_edge_detector_if.sv
// Bundle of per-channel level inputs, mode/clear controls and event outputs.
interface multi_edge_detector_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);

  logic [N_CH-1:0]       in;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH-1:0]       clr;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       flag;
  logic [N_CH*CNT_W-1:0] count;

  // Consumer side: drives levels and controls, observes events.
  modport master (
    output in, mode, clr,
    input  tick, flag, count
  );

  // Detector side.
  modport slave (
    input  in, mode, clr,
    output tick, flag, count
  );

endinterface

// File: rtl/edge_channel.sv
// One detector channel: synchroniser, edge FSM (Moore or Mealy), mode
// qualification, sticky flag and saturating edge counter.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MEALY       = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             tick,
  output logic             flag,
  output logic [CNT_W-1:0] count
);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic s;
  logic re;
  logic fe;
  logic rise_en;
  logic fall_en;

  // ---- stage p0: synchronise the raw level ----
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in_bit;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_p0;

    // Shift chain; bit 0 samples the raw input, the last bit is the clean level.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_p0 <= '0;
      end else begin
        sync_p0[0] <= in_bit;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_p0[k] <= sync_p0[k-1];
        end
      end
    end

    assign s = sync_p0[SYNC_STAGES-1];
  end

  // ---- stage p1: raw edge detection ----
  if (MEALY == 0) begin : g_moore
    edge_state_t state;

    // Edge FSM; RISE and FALL each last one cycle and decode directly to re/fe.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= ZERO;
      end else begin
        unique case (state)
          ZERO:    state <= s ? RISE : ZERO;
          RISE:    state <= s ? ONE  : FALL;
          ONE:     state <= s ? ONE  : FALL;
          FALL:    state <= s ? RISE : ZERO;
          default: state <= ZERO;
        endcase
      end
    end

    assign re = (state == RISE);
    assign fe = (state == FALL);
  end else begin : g_mealy
    logic lvl;

    // Previous synchronised level; edges are the difference against it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) lvl <= 1'b0;
      else       lvl <= s;
    end

    assign re = s & ~lvl;
    assign fe = ~s & lvl;
  end

  // Mode gates only the output so the FSM keeps tracking the level while
  // the channel is off; enabling it later cannot fake an edge.
  assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // Reset gating matters for the unsynchronised Mealy case, where the raw
  // input would otherwise reach tick while reset is held.
  assign tick = ~reset & ((re & rise_en) | (fe & fall_en));

  // ---- stage p2: event accumulation ----
  // Sticky flag: a tick wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     flag <= 1'b0;
    else if (tick) flag <= 1'b1;
    else if (clr)  flag <= 1'b0;
  end

  // Saturating counter: clear restarts at 0, or at 1 if an edge lands with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (clr)  count <= tick ? CNT_W'(1) : '0;
    else if (tick) count <= sat_inc(count);
  end

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent edge-detector channels behind a single interface port.
module multi_edge_detector #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MEALY       = 0,
  parameter int CNT_W       = 8
) (
  input logic                  clk,
  input logic                  reset,
  multi_edge_detector_if.slave bus
);

  logic [N_CH-1:0]       tick_v;
  logic [N_CH-1:0]       flag_v;
  logic [N_CH*CNT_W-1:0] count_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .MEALY      (MEALY),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .in_bit(bus.in[i]),
      .mode  (bus.mode[2*i +: 2]),
      .clr   (bus.clr[i]),
      .tick  (tick_v[i]),
      .flag  (flag_v[i]),
      .count (count_v[CNT_W*i +: CNT_W])
    );
  end

  assign bus.tick  = tick_v;
  assign bus.flag  = flag_v;
  assign bus.count = count_v;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: dut_a is Moore with 2 sync stages and 3-bit counters,
// dut_b is Mealy with no synchroniser and 8-bit counters. Inputs change on
// the falling clock edge and outputs are sampled 1 time unit later.
module tb_multi_edge_detector;

  localparam int N   = 4;
  localparam int CWA = 3;
  localparam int CWB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  multi_edge_detector_if #(.N_CH(N), .CNT_W(CWA)) ifa ();
  multi_edge_detector_if #(.N_CH(N), .CNT_W(CWB)) ifb ();

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(2), .MEALY(0), .CNT_W(CWA)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );

  multi_edge_detector #(.N_CH(N), .SYNC_STAGES(0), .MEALY(1), .CNT_W(CWB)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    ifa.in = '0; ifa.mode = '0; ifa.clr = '0;
    ifb.in = '0; ifb.mode = '0; ifb.clr = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (ifa.tick !== '0 || ifa.flag !== '0 || ifa.count !== '0) begin
      n_err++;
      $display("FAIL reset_a: tick=%b flag=%b count=%h required all zero", ifa.tick, ifa.flag, ifa.count);
    end
    n_cmp++;
    if (ifb.tick !== '0 || ifb.flag !== '0 || ifb.count !== '0) begin
      n_err++;
      $display("FAIL reset_b: tick=%b flag=%b count=%h required all zero", ifb.tick, ifb.flag, ifb.count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (ifa.tick !== '0 || ifb.tick !== '0) begin
        n_err++;
        $display("FAIL idle_after_reset t=%0d: tick_a=%b tick_b=%b required 0", t, ifa.tick, ifb.tick);
      end
    end
  endtask

  task automatic test_moore_both();
    logic [3:0] exp;
    ifa.mode = 8'b00_00_00_11;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      ifa.in = (t < 4) ? 4'b0001 : 4'b0000;
      #1;
      exp = (t == 3 || t == 7) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (ifa.tick !== exp) begin
        n_err++;
        $display("FAIL moore_tick t=%0d: got %b required %b", t, ifa.tick, exp);
      end
      if (t == 3) begin
        n_cmp++;
        if (ifa.count[2:0] !== 3'd0) begin
          n_err++;
          $display("FAIL moore_count_lag: got %0d required 0", ifa.count[2:0]);
        end
      end
      if (t == 4) begin
        n_cmp++;
        if (ifa.count[2:0] !== 3'd1 || ifa.flag[0] !== 1'b1) begin
          n_err++;
          $display("FAIL moore_after_rise: count=%0d flag=%b required 1/1", ifa.count[2:0], ifa.flag[0]);
        end
      end
    end
    n_cmp++;
    if (ifa.count[2:0] !== 3'd2 || ifa.flag !== 4'b0001) begin
      n_err++;
      $display("FAIL moore_final: count=%0d flag=%b required 2/0001", ifa.count[2:0], ifa.flag);
    end
  endtask

  task automatic test_mealy_rise();
    logic [3:0] exp;
    ifb.mode = 8'b00_00_01_00;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ifb.in = (t < 3) ? 4'b0010 : 4'b0000;
      #1;
      exp = (t == 0) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (ifb.tick !== exp) begin
        n_err++;
        $display("FAIL mealy_tick t=%0d: got %b required %b", t, ifb.tick, exp);
      end
    end
    n_cmp++;
    if (ifb.count[15:8] !== 8'd1 || ifb.flag !== 4'b0010) begin
      n_err++;
      $display("FAIL mealy_final: count=%0d flag=%b required 1/0010", ifb.count[15:8], ifb.flag);
    end
  endtask

  task automatic test_mode_gating();
    logic [3:0] v;
    logic [3:0] exp;
    ifa.mode = '0;
    for (int t = 0; t < 27; t++) begin
      @(negedge clk);
      v = '0;
      if (t < 10)      v[2] = ((t / 2) % 2) == 0;
      else if (t < 20) v[2] = 1'b1;
      else             v[2] = 1'b0;
      ifa.in = v;
      ifa.mode[5:4] = (t >= 15) ? 2'b10 : 2'b00;
      #1;
      exp = (t == 23) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (ifa.tick !== exp) begin
        n_err++;
        $display("FAIL gating_tick t=%0d: got %b required %b", t, ifa.tick, exp);
      end
    end
    n_cmp++;
    if (ifa.count[8:6] !== 3'd1 || ifa.flag[2] !== 1'b1) begin
      n_err++;
      $display("FAIL gating_final: count=%0d flag=%b required 1/1", ifa.count[8:6], ifa.flag[2]);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    ifa.clr = 4'b0001;
    @(negedge clk);
    ifa.clr = 4'b0000;
    #1;
    n_cmp++;
    if (ifa.count[2:0] !== 3'd0 || ifa.flag[0] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_ch0: count=%0d flag=%b required 0/0", ifa.count[2:0], ifa.flag[0]);
    end
    n_cmp++;
    if (ifa.count[8:6] !== 3'd1 || ifa.flag[2] !== 1'b1) begin
      n_err++;
      $display("FAIL clear_isolation: ch2 count=%0d flag=%b required 1/1", ifa.count[8:6], ifa.flag[2]);
    end
  endtask

  task automatic test_saturation();
    ifa.mode = 8'b01_00_00_00;
    for (int t = 0; t < 44; t++) begin
      @(negedge clk);
      ifa.in = (t < 40 && (t % 4) < 2) ? 4'b1000 : 4'b0000;
      #1;
      if (t == 28) begin
        n_cmp++;
        if (ifa.count[11:9] !== 3'd7) begin
          n_err++;
          $display("FAIL sat_reach: got %0d required 7", ifa.count[11:9]);
        end
      end
    end
    n_cmp++;
    if (ifa.count[11:9] !== 3'd7 || ifa.flag[3] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_hold: count=%0d flag=%b required 7/1", ifa.count[11:9], ifa.flag[3]);
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      ifa.in  = 4'b1000;
      ifa.clr = (t == 3) ? 4'b1000 : 4'b0000;
      #1;
      if (t == 3) begin
        n_cmp++;
        if (ifa.tick[3] !== 1'b1) begin
          n_err++;
          $display("FAIL clr_tick_edge: tick=%b required 1", ifa.tick[3]);
        end
      end
      if (t == 4) begin
        n_cmp++;
        if (ifa.count[11:9] !== 3'd1 || ifa.flag[3] !== 1'b1) begin
          n_err++;
          $display("FAIL clr_with_tick: count=%0d flag=%b required 1/1", ifa.count[11:9], ifa.flag[3]);
        end
      end
    end
    ifa.clr = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    ifa.mode = 8'b00_00_00_11;
    ifb.mode = 8'b00_00_01_00;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      ifa.in = 4'b0001;
      #1;
    end
    n_cmp++;
    if (ifa.tick !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_pre_tick: got %b required 0001", ifa.tick);
    end
    reset  = 1'b1;
    ifb.in = 4'b0010;
    #1;
    n_cmp++;
    if (ifa.tick !== '0 || ifa.flag !== '0 || ifa.count !== '0) begin
      n_err++;
      $display("FAIL mid_reset_a: tick=%b flag=%b count=%h required all zero", ifa.tick, ifa.flag, ifa.count);
    end
    n_cmp++;
    if (ifb.tick !== '0 || ifb.flag !== '0 || ifb.count !== '0) begin
      n_err++;
      $display("FAIL mid_reset_b: tick=%b flag=%b count=%h required all zero", ifb.tick, ifb.flag, ifb.count);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (ifa.tick !== '0 || ifb.tick !== '0) begin
        n_err++;
        $display("FAIL tick_in_reset: tick_a=%b tick_b=%b required 0", ifa.tick, ifb.tick);
      end
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 0) reset = 1'b0;
      #1;
      exp = (t == 3) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (ifa.tick !== exp) begin
        n_err++;
        $display("FAIL release_a t=%0d: got %b required %b", t, ifa.tick, exp);
      end
      exp = (t == 0) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (ifb.tick !== exp) begin
        n_err++;
        $display("FAIL release_b t=%0d: got %b required %b", t, ifb.tick, exp);
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp;
    @(negedge clk);
    ifa.in = '0;
    ifb.in = '0;
    reset  = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    ifa.mode = 8'hFF;
    ifb.mode = 8'hFF;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ifa.in = 4'b1111;
      ifb.in = 4'b1111;
      #1;
      exp = (t == 3) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (ifa.tick !== exp) begin
        n_err++;
        $display("FAIL multi_tick_a t=%0d: got %b required %b", t, ifa.tick, exp);
      end
      exp = (t == 0) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (ifb.tick !== exp) begin
        n_err++;
        $display("FAIL multi_tick_b t=%0d: got %b required %b", t, ifb.tick, exp);
      end
    end
    n_cmp++;
    if (ifa.count !== {4{3'd1}} || ifa.flag !== 4'b1111) begin
      n_err++;
      $display("FAIL multi_count_a: count=%h flag=%b required 249/1111", ifa.count, ifa.flag);
    end
    n_cmp++;
    if (ifb.count !== {4{8'd1}} || ifb.flag !== 4'b1111) begin
      n_err++;
      $display("FAIL multi_count_b: count=%h flag=%b required 01010101/1111", ifb.count, ifb.flag);
    end
  endtask

  initial begin
    test_reset();
    test_moore_both();
    test_mealy_rise();
    test_mode_gating();
    test_clear();
    test_saturation();
    test_reset_mid();
    test_multi();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
